isp_mode_ctrl: RTL

//  Sequences ISP pipeline mode changes for the ISP routing interconnect. Takes user key

---
 rtl/isp_mode_ctrl_if.sv | 20 ++
 rtl/isp_mode_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/isp_mode_ctrl_if.sv
// Host mode-request handshake between the host controller and isp_mode_ctrl.
// The host drives a request and the mode controller answers with req_ready
// in the cycle that it accepts the request.
interface isp_mode_ctrl_if;
    logic       req_valid;
    logic [3:0] req_mode;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_mode,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_mode,
        output req_ready
    );
endinterface

// File: rtl/isp_mode_ctrl.sv
// ISP pipeline mode sequencer. Key presses and host requests choose a target
// mode; the target is applied only on a vsync rising edge, and the HDMI output
// stays muted for MUTE_FRAMES frames after every switch so that partially
// flushed pipeline data never reaches the display.
module isp_mode_ctrl #(
    parameter int NUM_MODES       = 6,
    parameter int INIT_MODE       = 0,
    parameter int MUTE_FRAMES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_n,
    input  logic             vsync,
    isp_mode_ctrl_if.slave   req,
    output logic [3:0]       mode,
    output logic             mute,
    output logic             busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MC = $clog2(MUTE_FRAMES + 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        ARM  = 2'd1,
        MUTE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      mode_nx;
    logic            mute_nx;
    logic [MC-1:0]   mute_cnt;
    logic [MC-1:0]   mute_cnt_nx;
    logic            pend;
    logic            pend_nx;
    logic [3:0]      target;
    logic [3:0]      target_nx;

    logic            key_s1;
    logic            key_s2;
    logic            vs_s1;
    logic            vs_s2;
    logic            vs_s3;
    logic            vs_rise;

    logic [CW-1:0]   deb_cnt;
    logic            key_stable;
    logic            key_press;

    logic            accept;
    logic            req_in_range;

    // Bring the asynchronous key and vsync inputs into the clk domain and keep
    // one extra vsync stage for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            vs_s1  <= 1'b0;
            vs_s2  <= 1'b0;
            vs_s3  <= 1'b0;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
            vs_s1  <= vsync;
            vs_s2  <= vs_s1;
            vs_s3  <= vs_s2;
        end
    end

    assign vs_rise = vs_s2 & ~vs_s3;

    // Debounce: the synchronized key must differ from the stable key for
    // DEBOUNCE_CYCLES consecutive cycles; only a press (1->0) raises key_press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt    <= '0;
            key_stable <= 1'b1;
            key_press  <= 1'b0;
        end else if (key_s2 != key_stable) begin
            if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                deb_cnt    <= '0;
                key_stable <= key_s2;
                key_press  <= ~key_s2;
            end else begin
                deb_cnt    <= deb_cnt + CW'(1);
                key_press  <= 1'b0;
            end
        end else begin
            deb_cnt   <= '0;
            key_press <= 1'b0;
        end
    end

    assign req.req_ready = (state == RUN);
    assign accept        = req.req_valid && req.req_ready;
    assign req_in_range  = ({1'b0, req.req_mode} < 5'(NUM_MODES));
    assign busy          = (state != RUN);

    // Hold the mode-sequencer state; reset forces a muted start that waits
    // out MUTE_FRAMES frames before running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MUTE;
            mode     <= 4'(INIT_MODE);
            mute     <= 1'b1;
            mute_cnt <= '0;
            pend     <= 1'b0;
            target   <= 4'(INIT_MODE);
        end else begin
            state    <= state_nx;
            mode     <= mode_nx;
            mute     <= mute_nx;
            mute_cnt <= mute_cnt_nx;
            pend     <= pend_nx;
            target   <= target_nx;
        end
    end

    // Next-state logic: sequence RUN/ARM/MUTE on frame boundaries, then fold
    // in target updates, where an accepted host request overrides a key press.
    always_comb begin
        state_nx    = state;
        mode_nx     = mode;
        mute_nx     = mute;
        mute_cnt_nx = mute_cnt;
        pend_nx     = pend;
        target_nx   = target;

        case (state)
            RUN: begin
                mute_nx = 1'b0;
                if (pend) begin
                    pend_nx = 1'b0;
                    if (target != mode) begin
                        state_nx = ARM;
                    end
                end
            end
            ARM: begin
                if (vs_rise) begin
                    mode_nx     = target;
                    mute_nx     = 1'b1;
                    mute_cnt_nx = '0;
                    state_nx    = MUTE;
                end
            end
            MUTE: begin
                mute_nx = 1'b1;
                if (vs_rise) begin
                    if (mute_cnt == MC'(MUTE_FRAMES - 1)) begin
                        mute_nx  = 1'b0;
                        state_nx = RUN;
                    end else begin
                        mute_cnt_nx = mute_cnt + MC'(1);
                    end
                end
            end
            default: begin
                mute_nx     = 1'b1;
                mute_cnt_nx = '0;
                state_nx    = MUTE;
            end
        endcase

        if (accept) begin
            if (req_in_range) begin
                target_nx = req.req_mode;
                pend_nx   = 1'b1;
            end
        end else if (key_press) begin
            target_nx = (target == 4'(NUM_MODES - 1)) ? 4'd0 : target + 4'd1;
            pend_nx   = 1'b1;
        end
    end

endmodule
